// File: rtl/freq_gen_if.sv
// ============================================================================
// freq_gen_if : setpoint request / generator status bundle for freq_gen
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface freq_gen_if;
  logic        load;
  logic [19:0] bcd_in;
  logic        clk_out;
  logic        busy;
  logic        err;
  logic [19:0] freq_bin;

  modport master (output load, bcd_in, input clk_out, busy, err, freq_bin);
  modport slave  (input load, bcd_in, output clk_out, busy, err, freq_bin);
endinterface

`default_nettype wire

// File: rtl/freq_gen.sv
// ============================================================================
// freq_gen : BCD-programmed square-wave generator (CLK_HZ / (2*f) half period)
// Optional : FREQ_ROUND_EN selects round-to-nearest half period instead of floor
// Revision : 1.0
// ============================================================================
`default_nettype none

module freq_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  freq_gen_if.slave   bus
);

  localparam int c_step_raw = $clog2(DIV_W + 1);
  localparam int c_step_w   = (c_step_raw > 3) ? c_step_raw : 3;
  localparam logic [DIV_W-1:0] c_clk_hz = DIV_W'(CLK_HZ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_DIV   = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [19:0]         bcd_q, bcd_d;
  logic [19:0]         acc_q, acc_d;
  logic [c_step_w-1:0] step_q, step_d;
  logic [DIV_W-1:0]    dvd_q, dvd_d;
  logic [DIV_W-1:0]    quot_q, quot_d;
  logic [DIV_W:0]      rem_q, rem_d;
  logic [DIV_W-1:0]    half_q, half_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                clk_out_q, clk_out_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [19:0]         freq_bin_q, freq_bin_d;

  logic [3:0]          w_digit;
  logic [19:0]         w_acc_next;
  logic [DIV_W-1:0]    w_dividend;
  logic [DIV_W:0]      w_divisor;
  logic [DIV_W:0]      w_rem_shift;
  logic                w_ge;

  assign w_digit     = bcd_q[19:16];
  assign w_acc_next  = (acc_q << 3) + (acc_q << 1) + {16'd0, w_digit};
  assign w_divisor   = {{(DIV_W-20){1'b0}}, acc_q, 1'b0};
  assign w_rem_shift = {rem_q[DIV_W-1:0], dvd_q[DIV_W-1]};
  assign w_ge        = (w_rem_shift >= w_divisor);

`ifdef FREQ_ROUND_EN
  // Adding f before dividing by 2f rounds the half period to nearest
  assign w_dividend = c_clk_hz + {{(DIV_W-20){1'b0}}, w_acc_next};
`else
  assign w_dividend = c_clk_hz;
`endif

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    step_d     = step_q;
    dvd_d      = dvd_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    busy_d     = busy_q;
    err_d      = err_q;
    freq_bin_d = freq_bin_q;

    // Generator runs on the current half period regardless of FSM activity
    if (half_q == '0) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (cnt_q == half_q - DIV_W'(1)) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          bcd_d   = bus.bcd_in;
          acc_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (w_digit > 4'd9) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          acc_d = w_acc_next;
          bcd_d = {bcd_q[15:0], 4'd0};
          if (step_q == c_step_w'(4)) begin
            step_d  = '0;
            dvd_d   = w_dividend;
            rem_d   = '0;
            quot_d  = '0;
            state_d = S_DIV;
          end else begin
            step_d = step_q + c_step_w'(1);
          end
        end
      end
      S_DIV: begin
        rem_d  = w_ge ? (w_rem_shift - w_divisor) : w_rem_shift;
        quot_d = {quot_q[DIV_W-2:0], w_ge};
        dvd_d  = {dvd_q[DIV_W-2:0], 1'b0};
        if (step_q == c_step_w'(DIV_W - 1)) begin
          step_d  = '0;
          state_d = S_APPLY;
        end else begin
          step_d = step_q + c_step_w'(1);
        end
      end
      S_APPLY: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (acc_q == '0) begin
          half_d     = '0;
          cnt_d      = '0;
          clk_out_d  = 1'b0;
          freq_bin_d = '0;
          err_d      = 1'b0;
        end else if (quot_q == '0) begin
          err_d = 1'b1;
        end else begin
          // Holding the current level on the switch edge avoids a runt pulse
          half_d     = quot_q;
          cnt_d      = '0;
          clk_out_d  = clk_out_q;
          freq_bin_d = acc_q;
          err_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      dvd_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      half_q     <= '0;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      freq_bin_q <= '0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      dvd_q      <= dvd_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      freq_bin_q <= freq_bin_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.freq_bin = freq_bin_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_gen.sv
// ============================================================================
// tb_freq_gen : randomized self-checking bench for freq_gen
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_freq_gen;
  localparam int CLK_HZ = 50000000;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  // Reference state: what the applied setpoint should be
  longint m_half;
  longint m_freq;
  bit     m_err;

  freq_gen_if bus ();

  freq_gen #(.CLK_HZ(CLK_HZ), .DIV_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint exp_half(longint f);
`ifdef FREQ_ROUND_EN
    return (CLK_HZ + f) / (2 * f);
`else
    return CLK_HZ / (2 * f);
`endif
  endfunction

  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Applies the setpoint rules to the model; returns expected busy length
  task automatic model_load(input logic [19:0] bcd, output int exp_busy);
    int     bad;
    longint f;
    longint h;
    logic [3:0] d;
    bad = -1;
    f   = 0;
    for (int i = 0; i < 5; i++) begin
      d = bcd[19 - 4*i -: 4];
      if (d > 9 && bad < 0) bad = i;
      f = f * 10 + d;
    end
    if (bad >= 0) begin
      exp_busy = bad + 1;
      m_err    = 1'b1;
    end else begin
      exp_busy = 38;
      if (f == 0) begin
        m_half = 0; m_freq = 0; m_err = 1'b0;
      end else begin
        h = exp_half(f);
        if (h == 0) m_err = 1'b1;
        else begin
          m_half = h; m_freq = f; m_err = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_load(input logic [19:0] v);
    @(negedge clk);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure(input longint half, output int hi, output int lo, output bit ok);
    int lim;
    lim = int'(3 * half) + 20;
    hi = 0; lo = 0; ok = 1'b1;
    for (int i = 0; i < lim && bus.clk_out; i++) @(negedge clk);
    for (int i = 0; i < lim && !bus.clk_out; i++) @(negedge clk);
    if (!bus.clk_out) ok = 1'b0;
    while (ok && bus.clk_out && hi < lim) begin hi++; @(negedge clk); end
    while (ok && !bus.clk_out && lo < lim) begin lo++; @(negedge clk); end
  endtask

  task automatic do_reset();
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    m_half = 0; m_freq = 0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.clk_out, bus.busy, bus.err} !== 3'b000 || bus.freq_bin !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: clk_out=%b busy=%b err=%b freq_bin=%0d, required 0/0/0/0",
               bus.clk_out, bus.busy, bus.err, bus.freq_bin);
    end
  endtask

  task automatic test_basic_1000();
    int n, eb;
    model_load(20'h01000, eb);
    pulse_load(20'h01000);
    wait_busy(n);
    tests_run++;
    if (n !== 38) begin
      tests_failed++;
      $display("FAIL busy_1000: busy cycles=%0d, required 38", n);
    end
    tests_run++;
    if (bus.freq_bin !== 20'd1000 || bus.err !== 1'b0 || dut.half_q !== 32'(m_half) || m_half != 25000) begin
      tests_failed++;
      $display("FAIL apply_1000: freq_bin=%0d err=%b half=%0d, required 1000/0/25000",
               bus.freq_bin, bus.err, dut.half_q);
    end
  endtask

  task automatic test_bad_digit();
    int n, eb;
    logic lvl;
    bit toggled;
    model_load(20'h0A000, eb);
    pulse_load(20'h0A000);
    wait_busy(n);
    tests_run++;
    if (n !== eb || bus.err !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_bad_digit: busy=%0d err=%b, required %0d/1", n, bus.err, eb);
    end
    tests_run++;
    if (bus.freq_bin !== 20'd1000 || dut.half_q !== 32'(m_half)) begin
      tests_failed++;
      $display("FAIL abort_keeps: freq_bin=%0d half=%0d, required 1000/%0d",
               bus.freq_bin, dut.half_q, m_half);
    end
    lvl = bus.clk_out;
    toggled = 1'b0;
    for (int i = 0; i < 25002 && !toggled; i++) begin
      @(negedge clk);
      if (bus.clk_out !== lvl) toggled = 1'b1;
    end
    tests_run++;
    if (!toggled) begin
      tests_failed++;
      $display("FAIL abort_running: clk_out stuck at %b, required a toggle within 25000", lvl);
    end
    model_load(20'h00500, eb);
    pulse_load(20'h00500);
    wait_busy(n);
    tests_run++;
    if (bus.err !== 1'b0 || dut.half_q !== 32'd50000 || bus.freq_bin !== 20'd500) begin
      tests_failed++;
      $display("FAIL recover_500: err=%b half=%0d freq_bin=%0d, required 0/50000/500",
               bus.err, dut.half_q, bus.freq_bin);
    end
  endtask

  task automatic test_seven();
    int n, eb;
    model_load(20'h00007, eb);
    pulse_load(20'h00007);
    wait_busy(n);
    tests_run++;
`ifdef FREQ_ROUND_EN
    if (dut.half_q !== 32'd3571429 || bus.freq_bin !== 20'd7) begin
`else
    if (dut.half_q !== 32'd3571428 || bus.freq_bin !== 20'd7) begin
`endif
      tests_failed++;
      $display("FAIL half_7hz: half=%0d freq_bin=%0d, required %0d/7", dut.half_q, bus.freq_bin, m_half);
    end
  endtask

  task automatic test_stop();
    int n, eb, highs;
    // Run fast first so clk_out is likely high when stop applies
    model_load(to_bcd(90000), eb);
    pulse_load(to_bcd(90000));
    wait_busy(n);
    model_load(20'h00000, eb);
    pulse_load(20'h00000);
    wait_busy(n);
    tests_run++;
    if (bus.clk_out !== 1'b0 || bus.freq_bin !== 20'd0 || bus.err !== 1'b0 || n !== 38) begin
      tests_failed++;
      $display("FAIL stop_apply: clk_out=%b freq_bin=%0d err=%b busy=%0d, required 0/0/0/38",
               bus.clk_out, bus.freq_bin, bus.err, n);
    end
    highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.clk_out !== 1'b0) highs++;
    end
    tests_run++;
    if (highs !== 0) begin
      tests_failed++;
      $display("FAIL stop_hold: clk_out high for %0d cycles, required 0", highs);
    end
  endtask

  task automatic test_back_to_back();
    int n, eb, hi, lo;
    bit ok;
    model_load(to_bcd(50000), eb);
    pulse_load(to_bcd(50000));
    n = 1;
    repeat (9) begin @(negedge clk); if (bus.busy) n++; end
    bus.load   = 1'b1;
    bus.bcd_in = to_bcd(20000);
    @(negedge clk);
    if (bus.busy) n++;
    bus.load   = 1'b0;
    while (bus.busy && n < 200) begin @(negedge clk); if (bus.busy) n++; end
    tests_run++;
    if (n !== 38 || bus.freq_bin !== 20'd50000 || dut.half_q !== 32'(m_half)) begin
      tests_failed++;
      $display("FAIL back_to_back: busy=%0d freq_bin=%0d half=%0d, required 38/50000/%0d",
               n, bus.freq_bin, dut.half_q, m_half);
    end
    measure(m_half, hi, lo, ok);
    tests_run++;
    if (!ok || hi !== int'(m_half) || lo !== int'(m_half)) begin
      tests_failed++;
      $display("FAIL period_50k: high=%0d low=%0d, required %0d/%0d", hi, lo, m_half, m_half);
    end
  endtask

  task automatic test_reset_mid();
    int n, eb, hi, lo;
    bit ok;
    pulse_load(to_bcd(12345));
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_half = 0; m_freq = 0; m_err = 1'b0;
    tests_run++;
    if ({bus.clk_out, bus.busy, bus.err} !== 3'b000 || bus.freq_bin !== 20'd0 || dut.half_q !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_div: clk_out=%b busy=%b err=%b freq_bin=%0d half=%0d, required all 0",
               bus.clk_out, bus.busy, bus.err, bus.freq_bin, dut.half_q);
    end
    n = 0;
    repeat (40) begin @(negedge clk); if (bus.busy) n++; end
    tests_run++;
    if (n !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy seen %0d cycles after reset, required 0", n);
    end
    model_load(20'h99999, eb);
    pulse_load(20'h99999);
    wait_busy(n);
    measure(m_half, hi, lo, ok);
    tests_run++;
    if (!ok || dut.half_q !== 32'd250 || hi !== 250 || lo !== 250) begin
      tests_failed++;
      $display("FAIL half_99999: half=%0d high=%0d low=%0d, required 250/250/250",
               dut.half_q, hi, lo);
    end
  endtask

  task automatic test_random();
    int n, eb, hi, lo, f, pos;
    bit ok;
    logic [19:0] v;
    for (int t = 0; t < 20; t++) begin
      f = ($urandom_range(0, 1) == 1) ? int'($urandom_range(41667, 99999))
                                      : int'($urandom_range(0, 99999));
      v = to_bcd(f);
      if ($urandom_range(0, 3) == 0) begin
        pos = int'($urandom_range(0, 4));
        v[pos*4 +: 4] = 4'($urandom_range(10, 15));
      end
      model_load(v, eb);
      pulse_load(v);
      wait_busy(n);
      tests_run++;
      if (n !== eb || bus.err !== m_err || bus.freq_bin !== 20'(m_freq) || dut.half_q !== 32'(m_half)) begin
        tests_failed++;
        $display("FAIL random_load %h: busy=%0d err=%b freq_bin=%0d half=%0d, required %0d/%b/%0d/%0d",
                 v, n, bus.err, bus.freq_bin, dut.half_q, eb, m_err, m_freq, m_half);
      end
      if (m_half != 0 && m_half <= 600) begin
        measure(m_half, hi, lo, ok);
        tests_run++;
        if (!ok || hi !== int'(m_half) || lo !== int'(m_half)) begin
          tests_failed++;
          $display("FAIL random_period f=%0d: high=%0d low=%0d, required %0d/%0d",
                   m_freq, hi, lo, m_half, m_half);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    test_reset();
    test_basic_1000();
    test_bad_digit();
    test_seven();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
